// File: rtl/kronos_types.sv
// Shared type and width definitions for the Kronos memory-side blocks.
package kronos_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam int ARB_STREAK_W = 4;
    localparam int ARB_TIMER_W  = 16;

endpackage

// File: rtl/kronos_mem_arbiter.sv
// Two-requester arbiter for the single memory port: data has priority, fetch is
// guaranteed progress by a streak cap, and an optional timer aborts hung slaves.
module kronos_mem_arbiter
    import kronos_types::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_rd_data,
    output logic        instr_err,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_wr_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic        data_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data
);

    localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_DATA_STREAK);
    localparam logic [ARB_TIMER_W-1:0]  TMO_LAST   = ARB_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam bit                      TMO_EN     = (TIMEOUT_CYCLES > 0);

    arb_state_t              state_q, state_d;
    logic [ARB_STREAK_W-1:0] streak_q, streak_d;
    logic [ARB_TIMER_W-1:0]  timer_q, timer_d;
    logic                    timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        timer_d       = timer_q;
        mem_req       = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr      = instr_addr;
        mem_wr_data   = '0;
        mem_wr_mask   = '0;
        instr_ack     = 1'b0;
        data_ack      = 1'b0;
        instr_err     = 1'b0;
        data_err      = 1'b0;
        instr_rd_data = mem_rd_data;
        data_rd_data  = mem_rd_data;
        // Ack arriving on the expiry cycle takes precedence over the abort.
        timeout_hit   = TMO_EN && (timer_q == TMO_LAST) && !mem_ack;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (data_req && (!instr_req || streak_q < STREAK_MAX)) begin
                    state_d  = GNT_D;
                    streak_d = instr_req ? streak_q + 1'b1 : '0;
                end else if (instr_req) begin
                    state_d  = GNT_I;
                    streak_d = '0;
                end
            end
            GNT_I: begin
                mem_req   = 1'b1;
                instr_ack = mem_ack;
                instr_err = timeout_hit;
                if (mem_ack || timeout_hit) begin
                    state_d = IDLE;
                end else if (TMO_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GNT_D: begin
                mem_req     = 1'b1;
                mem_wr_en   = data_wr_en;
                mem_addr    = data_addr;
                mem_wr_data = data_wr_data;
                mem_wr_mask = data_wr_mask;
                data_ack    = mem_ack;
                data_err    = timeout_hit;
                if (mem_ack || timeout_hit) begin
                    state_d = IDLE;
                end else if (TMO_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Scoreboard bench for kronos_mem_arbiter: stimulus queues expected grants and
// responses, a monitor pops and compares them as the bus presents them.
module tb_kronos_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_addr = '0;
    logic        instr_req = 1'b0;
    logic        instr_ack, instr_err;
    logic [31:0] instr_rd_data;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic [3:0]  data_wr_mask = '0;
    logic        data_wr_en = 1'b0;
    logic        data_req = 1'b0;
    logic        data_ack, data_err;
    logic [31:0] data_rd_data;
    logic [31:0] mem_addr, mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_en, mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;

    always #5 clk = ~clk;

    kronos_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack),
        .instr_rd_data(instr_rd_data), .instr_err(instr_err),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
        .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack),
        .data_rd_data(data_rd_data), .data_err(data_err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_wr_en(mem_wr_en), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_rd_data(mem_rd_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr_en;
        logic [31:0] wr_data;
        logic [3:0]  mask;
        logic        chk_data;
    } grant_t;

    typedef struct {
        logic [3:0]  rv;     // {instr_ack, data_ack, instr_err, data_err}
        int          gcyc;   // grant cycle (1-based) the response must land on
        logic [31:0] rd;
    } resp_t;

    grant_t exp_g[$];
    resp_t  exp_r[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     resp_seen = 0;
    int     nresp = 0;

    int     ack_on = 0;       // grant cycle on which the slave acks; 0 = never
    logic   idle_ack = 1'b0;  // drive a spurious ack while no grant is active
    int     scnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_g(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] m, input logic cd);
        grant_t g;
        g.addr = a; g.wr_en = we; g.wr_data = wd; g.mask = m; g.chk_data = cd;
        exp_g.push_back(g);
    endtask

    task automatic push_r(input logic [3:0] rv, input int gc, input logic [31:0] rd);
        resp_t r;
        r.rv = rv; r.gcyc = gc; r.rd = rd;
        exp_r.push_back(r);
        nresp++;
    endtask

    task automatic wait_resp(input string name);
        int g;
        g = 0;
        while (resp_seen < nresp && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (resp_seen < nresp) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d responses expected %0d", name, resp_seen, nresp);
        end
        @(posedge clk);
        #1;
    endtask

    // Slave model: acks on a chosen grant cycle, read data derived from address.
    always @(negedge clk) begin
        if (mem_req) begin
            scnt++;
            mem_ack = (ack_on > 0) && (scnt == ack_on);
        end else begin
            scnt = 0;
            mem_ack = idle_ack;
        end
        mem_rd_data = 32'hA500_0000 ^ mem_addr;
    end

    logic       prev_req = 1'b0;
    logic       bubble_chk = 1'b0;
    int         gcnt = 0;

    always @(negedge clk) begin
        logic [3:0] rv;
        grant_t g;
        resp_t  r;
        #1;
        if (bubble_chk) begin
            check("bubble_mem_req", 32'(mem_req), 32'd0);
            bubble_chk = 1'b0;
        end
        if (mem_req && !prev_req) begin
            gcnt = 1;
            if (exp_g.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_grant: got addr %h expected no grant", mem_addr);
            end else begin
                g = exp_g.pop_front();
                check("grant_addr", mem_addr, g.addr);
                check("grant_wr_en", 32'(mem_wr_en), 32'(g.wr_en));
                if (g.chk_data) begin
                    check("grant_wr_data", mem_wr_data, g.wr_data);
                    check("grant_wr_mask", 32'(mem_wr_mask), 32'(g.mask));
                end
            end
        end else if (mem_req) begin
            gcnt++;
        end else begin
            gcnt = 0;
        end
        prev_req = mem_req;

        rv = {instr_ack, data_ack, instr_err, data_err};
        if (rv != 4'b0000) begin
            resp_seen++;
            bubble_chk = 1'b1;
            if (exp_r.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got %b expected none", rv);
            end else begin
                r = exp_r.pop_front();
                check("resp_kind", 32'(rv), 32'(r.rv));
                check("resp_cycle", 32'(gcnt), 32'(r.gcyc));
                if (r.rv[3]) check("instr_rd_data", instr_rd_data, r.rd);
                if (r.rv[2]) check("data_rd_data", data_rd_data, r.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_acks_errs", 32'({instr_ack, data_ack, instr_err, data_err}), 32'd0);
        rst = 1'b0;

        // Fetch only, slave acks two cycles after mem_req rises.
        ack_on = 3;
        instr_addr = 32'h0000_0100;
        instr_req = 1'b1;
        push_g(32'h0000_0100, 1'b0, '0, '0, 1'b0);
        push_r(4'b1000, 3, 32'hA500_0100);
        @(posedge clk);
        #1;
        check("t1_latency_mem_req", 32'(mem_req), 32'd1);
        wait_resp("t1");
        instr_req = 1'b0;

        // Both requesting continuously with a zero-wait slave.
        ack_on = 1;
        instr_addr = 32'h0000_0300;
        data_addr = 32'h0000_0400;
        data_wr_data = 32'h0;
        data_wr_mask = 4'h0;
        data_wr_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                push_g(32'h0000_0300, 1'b0, '0, '0, 1'b0);
                push_r(4'b1000, 1, 32'hA500_0300);
            end else begin
                push_g(32'h0000_0400, 1'b0, 32'h0, 4'h0, 1'b1);
                push_r(4'b0100, 1, 32'hA500_0400);
            end
        end
        instr_req = 1'b1;
        data_req = 1'b1;
        wait_resp("t2");
        instr_req = 1'b0;
        data_req = 1'b0;
        check("t2_streak_after_i", 32'(dut.streak_q), 32'd0);

        // Data store.
        ack_on = 2;
        data_addr = 32'h0000_2000;
        data_wr_data = 32'hDEAD_BEEF;
        data_wr_mask = 4'b0011;
        data_wr_en = 1'b1;
        data_req = 1'b1;
        push_g(32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        push_r(4'b0100, 2, 32'hA500_2000);
        wait_resp("t3");
        data_req = 1'b0;
        data_wr_en = 1'b0;

        // Hung slave: abort on the eighth grant cycle.
        ack_on = 0;
        data_addr = 32'h0000_0500;
        data_wr_data = 32'h1234_5678;
        data_wr_mask = 4'hF;
        data_req = 1'b1;
        push_g(32'h0000_0500, 1'b0, 32'h1234_5678, 4'hF, 1'b1);
        push_r(4'b0001, 8, 32'h0);
        wait_resp("t4");
        data_req = 1'b0;

        // Ack exactly at the expiry cycle wins over the error.
        ack_on = 8;
        data_addr = 32'h0000_0600;
        data_req = 1'b1;
        push_g(32'h0000_0600, 1'b0, 32'h1234_5678, 4'hF, 1'b1);
        push_r(4'b0100, 8, 32'hA500_0600);
        wait_resp("t5");
        data_req = 1'b0;

        // Spurious ack with no owner is not forwarded.
        idle_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            check("t6_idle_resp", 32'({instr_ack, data_ack, instr_err, data_err}), 32'd0);
            check("t6_idle_mem_req", 32'(mem_req), 32'd0);
        end
        idle_ack = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a fetch grant.
        ack_on = 0;
        instr_addr = 32'h0000_0700;
        instr_req = 1'b1;
        push_g(32'h0000_0700, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t7_pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("t7_async_mem_req", 32'(mem_req), 32'd0);
        check("t7_async_acks_errs", 32'({instr_ack, data_ack, instr_err, data_err}), 32'd0);
        @(posedge clk);
        #1;
        check("t7_streak", 32'(dut.streak_q), 32'd0);
        check("t7_timer", 32'(dut.timer_q), 32'd0);
        rst = 1'b0;
        push_g(32'h0000_0700, 1'b0, '0, '0, 1'b0);
        push_r(4'b0010, 8, 32'h0);
        @(posedge clk);
        #1;
        check("t7_regrant_mem_req", 32'(mem_req), 32'd1);
        check("t7_regrant_timer", 32'(dut.timer_q), 32'd0);
        wait_resp("t7");
        instr_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("leftover_grants", 32'(exp_g.size()), 32'd0);
        check("leftover_resps", 32'(exp_r.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
Shares one memory port between the instruction-fetch requester and the write-back LSU data requester. The block sits between the core and the system memory/bus.
- Transactions are non-overlapping: one owner at a time, held from grant until ack.
- Data port has fixed priority, with an anti-starvation cap guaranteeing fetch progress.
- Optional ack timeout converts a hung slave into a one-cycle error to the owner.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while instr_req is pending before instr is forced to win (1..15)
TIMEOUT_CYCLES, 0, grant cycles without mem_ack before abort; 0 disables timeout (0..65535)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
instr_addr  in  32  fetch address
instr_req  in  1  fetch request, held until instr_ack/instr_err
instr_ack  out  1  fetch done, read data valid this cycle
instr_rd_data  out  32  fetch read data
instr_err  out  1  fetch aborted by timeout
data_addr  in  32  LSU address
data_wr_data  in  32  LSU store data
data_wr_mask  in  4  LSU byte mask
data_wr_en  in  1  LSU write (1) / read (0)
data_req  in  1  LSU request, held until data_ack/data_err
data_ack  out  1  LSU done
data_rd_data  out  32  LSU read data
data_err  out  1  LSU aborted by timeout
mem_addr  out  32  shared port address
mem_wr_data  out  32  shared port store data
mem_wr_mask  out  4  shared port mask
mem_wr_en  out  1  shared port write
mem_req  out  1  shared port request
mem_ack  in  1  slave completion
mem_rd_data  in  32  slave read data

Behaviour:
- States:
  - IDLE: no owner.
  - GNT_I: instruction port owns the bus.
  - GNT_D: data port owns the bus.
  - State register and owner are registered.
- Reset (any time, including mid-transaction):
  - state = IDLE; streak = 0; timer = 0.
  - mem_req, mem_wr_en, instr_ack, data_ack, instr_err, data_err = 0.
  - Any in-flight slave transaction is abandoned; the requester must re-request.
- IDLE arbitration, evaluated each cycle:
  - Only data_req: GNT_D.
  - Only instr_req: GNT_I.
  - Both requests:
    - GNT_D if streak < MAX_DATA_STREAK; streak increments.
    - Otherwise GNT_I.
  - Neither request: stay IDLE.
  - Any GNT_I resets streak to 0.
  - A GNT_D taken while instr_req is low also resets streak to 0.
- Latency: request seen in IDLE at cycle t → mem_req = 1 at t+1.
  - A zero-wait slave acks at t+1.
  - The requester sees its ack combinationally in the same cycle as mem_ack.
- Grant state:
  - mem_req = 1.
  - mem_addr, mem_wr_data and mem_wr_mask are muxed combinationally from the owner.
  - mem_wr_en = data_wr_en in GNT_D; 0 in GNT_I.
- Outputs outside a grant:
  - In IDLE: mem_req = 0, mem_wr_en = 0; address/data mux defaults to the instruction port.
  - instr_rd_data and data_rd_data = mem_rd_data at all times.
- Ack routing:
  - instr_ack = mem_ack & GNT_I; data_ack = mem_ack & GNT_D.
  - mem_ack in IDLE is ignored and not forwarded.
  - On ack, next state = IDLE.
  - One bubble cycle always follows each transaction; there is no back-to-back grant.
- Timeout (TIMEOUT_CYCLES > 0):
  - The timer clears on grant entry and counts each grant cycle with mem_ack = 0.
  - When timer == TIMEOUT_CYCLES-1 and mem_ack = 0:
    - owner's err = 1 for that single cycle;
    - mem_req stays 1 that cycle;
    - next state = IDLE.
  - mem_ack in the same cycle as expiry: ack wins, no err.
- Requester obligations:
  - Address, data and mask stay stable while req is high.
  - Dropping req mid-grant is illegal; the arbiter keeps mem_req asserted until ack or timeout.
- Widths:
  - streak counter: 4 bits, saturates at MAX_DATA_STREAK.
  - timer: 16 bits.
- Deadlock freedom: every grant ends by ack or timeout.

Decomposition:
- kronos_types package gains:
  - arb_state_t enum {IDLE, GNT_I, GNT_D} (2-bit);
  - ARB_STREAK_W = 4;
  - ARB_TIMER_W = 16.
- No sub-module: priority pick, streak counter and timer are small enough to live in kronos_mem_arbiter.

Test Plan:
- Only instr_req=1 at cycle 0, addr 0x100, slave acks 2 cycles after mem_req.
  → mem_req rises cycle 1, mem_addr=0x100, mem_wr_en=0.
  → instr_ack=1 cycle 3, mem_req=0 cycle 4.
- data_req and instr_req both held high continuously, zero-wait slave, MAX_DATA_STREAK=4.
  → grant order D,D,D,D,I,D,D,D,D,I…
  → each grant separated by one IDLE cycle.
- Data store: addr 0x2000, wr_data 0xDEADBEEF, mask 4'b0011, data_wr_en=1.
  → mem bus carries those exact values with mem_wr_en=1.
  → instr_ack never pulses.
- TIMEOUT_CYCLES=8, data_req, slave never acks.
  → data_err=1 exactly on the 8th grant cycle, data_ack=0.
  → state IDLE next cycle, mem_req=0.
- TIMEOUT_CYCLES=8, mem_ack arrives on the 8th grant cycle.
  → data_ack=1, data_err=0.
- rst pulsed while in GNT_I with mem_req=1.
  → mem_req=0 immediately (async).
  → after release, with instr_req still high, re-grant 1 cycle later.
  → streak and timer read 0.
